// File: rtl/reaction_pkg.sv
// Shared constants, LED cue encoding and state codes for the reaction-test sequencer.
package reaction_pkg;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b001;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b100;
    localparam logic [2:0] COL_WHITE = 3'b111;

    localparam logic BR_FULL = 1'b1;
    localparam logic BR_SEMI = 1'b0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_GO    = 3'd2;
    localparam logic [2:0] ST_SHOW  = 3'd3;
    localparam logic [2:0] ST_FALSE = 3'd4;
    localparam logic [2:0] ST_TOUT  = 3'd5;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic [2:0] c1;
        logic       b1;
        logic [2:0] c2;
        logic       b2;
    } led_cue_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // LED pair shown while the FSM sits in a given state; best selects the new-record SHOW cue.
    function automatic led_cue_t cue_of(input logic [2:0] st, input logic best);
        led_cue_t c;
        c.c1 = COL_WHITE;
        c.b1 = BR_SEMI;
        c.c2 = COL_BLACK;
        c.b2 = BR_FULL;
        case (st)
            ST_WAIT: begin
                c.c1 = COL_RED;
                c.b1 = BR_FULL;
            end
            ST_GO: begin
                c.c1 = COL_GREEN;
                c.b1 = BR_FULL;
            end
            ST_SHOW: begin
                c.c1 = COL_BLACK;
                c.b1 = BR_FULL;
                c.c2 = best ? COL_WHITE : COL_GREEN;
            end
            ST_FALSE: begin
                c.c1 = COL_RED;
                c.b1 = BR_SEMI;
                c.c2 = COL_RED;
            end
            ST_TOUT: begin
                c.c1 = COL_BLACK;
                c.b1 = BR_FULL;
                c.c2 = COL_BLUE;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the terminal count; clr restarts the phase.
module ms_tick_gen #(
    parameter int TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/reaction_cue_ctrl.sv
// Reaction-test sequencer driving two RGB LEDs; BEST_SCORE_EN adds a best-time register and output.
//   state | meaning
//   IDLE  | waiting for start
//   WAIT  | red ready cue, random delay running
//   GO    | green go cue, timing the press
//   SHOW  | valid result on display
//   FALSE | pressed before go
//   TOUT  | no press within the timeout
module reaction_cue_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV    = 100_000,
    parameter int MIN_WAIT_MS = 1000,
    parameter int RAND_BITS   = 10,
    parameter int TIMEOUT_MS  = 2000,
    parameter int HOLD_MS     = 3000,
    parameter int RESULT_W    = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                btn,
    output logic [2:0]          color1,
    output logic                bright1,
    output logic [2:0]          color2,
    output logic                bright2,
    output logic [RESULT_W-1:0] result_ms,
    output logic                result_valid,
`ifdef BEST_SCORE_EN
    output logic [RESULT_W-1:0] best_ms,
`endif
    output logic                busy
);

    localparam int MS_MAX = max3(MIN_WAIT_MS + (1 << RAND_BITS) - 1, TIMEOUT_MS, HOLD_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    logic [2:0]          state_q;
    logic [2:0]          state_d;
    logic                state_chg;
    logic                capture;
    logic                tick;
    logic [15:0]         lfsr_q;
    logic                lfsr_fb;
    logic [MS_W-1:0]     ms_q;
    logic [MS_W-1:0]     wait_q;
    logic [RESULT_W-1:0] res_cap_q;
    logic                res_pend_q;
    logic                show_best;
    led_cue_t            cue;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (btn)                 state_d = ST_FALSE;
                else if (ms_q == wait_q) state_d = ST_GO;
            end
            ST_GO: begin
                if (btn)                               state_d = ST_SHOW;
                else if (ms_q == MS_W'(TIMEOUT_MS))    state_d = ST_TOUT;
            end
            ST_SHOW, ST_FALSE, ST_TOUT: begin
                if (start)                          state_d = ST_WAIT;
                else if (ms_q == MS_W'(HOLD_MS))    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state_chg = (state_d != state_q);
    assign capture   = (state_q == ST_GO) && (state_d == ST_SHOW);
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_chg),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= LFSR_SEED;
            ms_q       <= '0;
            wait_q     <= '0;
            res_cap_q  <= '0;
            res_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= {lfsr_q[14:0], lfsr_fb};
            res_pend_q <= capture;
            if (state_chg) begin
                ms_q <= '0;
            end else if (tick && (state_q != ST_IDLE)) begin
                ms_q <= ms_q + 1'b1;
            end
            if (state_chg && (state_d == ST_WAIT)) begin
                wait_q <= MS_W'(MIN_WAIT_MS) + MS_W'(lfsr_q[RAND_BITS-1:0]);
            end
            // ms_q equals TIMEOUT_MS here when the press coincides with the timeout
            if (capture) begin
                res_cap_q <= RESULT_W'(ms_q);
            end
        end
    end

`ifdef BEST_SCORE_EN
    logic [RESULT_W-1:0] best_q;
    logic                show_best_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            best_q      <= '1;
            show_best_q <= 1'b0;
        end else begin
            if (capture) begin
                show_best_q <= (RESULT_W'(ms_q) < best_q);
            end
            if (res_pend_q && (res_cap_q < best_q)) begin
                best_q <= res_cap_q;
            end
        end
    end

    assign best_ms   = best_q;
    assign show_best = show_best_q;
`else
    assign show_best = 1'b0;
`endif

    assign cue = cue_of(state_q, show_best);

    // Outputs lag the state register by one clock so the cue and result_valid line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            color1       <= COL_WHITE;
            bright1      <= BR_SEMI;
            color2       <= COL_BLACK;
            bright2      <= BR_FULL;
            busy         <= 1'b0;
            result_ms    <= '0;
            result_valid <= 1'b0;
        end else begin
            color1       <= cue.c1;
            bright1      <= cue.b1;
            color2       <= cue.c2;
            bright2      <= cue.b2;
            busy         <= (state_q != ST_IDLE);
            result_valid <= res_pend_q;
            if (res_pend_q) begin
                result_ms <= res_cap_q;
            end
        end
    end

endmodule

// File: tb/tb_reaction_cue_ctrl.sv
// Directed bench for reaction_cue_ctrl with small timing parameters; build with BEST_SCORE_EN for the best-time checks.
module tb_reaction_cue_ctrl;
    import reaction_pkg::*;

    localparam int TICK_DIV    = 10;
    localparam int MIN_WAIT_MS = 4;
    localparam int RAND_BITS   = 3;
    localparam int TIMEOUT_MS  = 20;
    localparam int HOLD_MS     = 8;
    localparam int RESULT_W    = 12;
`ifdef BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                btn = 1'b0;
    logic [2:0]          color1;
    logic                bright1;
    logic [2:0]          color2;
    logic                bright2;
    logic [RESULT_W-1:0] result_ms;
    logic                result_valid;
    logic                busy;
`ifdef BEST_SCORE_EN
    logic [RESULT_W-1:0] best_ms;
`endif

    reaction_cue_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .MIN_WAIT_MS (MIN_WAIT_MS),
        .RAND_BITS   (RAND_BITS),
        .TIMEOUT_MS  (TIMEOUT_MS),
        .HOLD_MS     (HOLD_MS),
        .RESULT_W    (RESULT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .btn          (btn),
        .color1       (color1),
        .bright1      (bright1),
        .color2       (color2),
        .bright2      (bright2),
        .result_ms    (result_ms),
        .result_valid (result_valid),
`ifdef BEST_SCORE_EN
        .best_ms      (best_ms),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int red_cnt = 0;
    int model_best = 4095;

    always @(negedge clk) begin
        if (result_valid === 1'b1) valid_cnt++;
    end

    typedef struct {
        logic                s;
        logic                b;
        int                  w;
        logic [2:0]          c1;
        logic                b1;
        logic [2:0]          c2;
        logic                b2;
        logic                bz;
        logic [RESULT_W-1:0] res;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic b);
        start = s;
        btn   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        btn   = 1'b0;
    endtask

    task automatic chk_cue(input string tag, input logic [2:0] c1, input logic b1,
                           input logic [2:0] c2, input logic b2, input logic bz);
        chk({tag, ".color1"},  32'(color1),  32'(c1));
        chk({tag, ".bright1"}, 32'(bright1), 32'(b1));
        chk({tag, ".color2"},  32'(color2),  32'(c2));
        chk({tag, ".bright2"}, 32'(bright2), 32'(b2));
        chk({tag, ".busy"},    32'(busy),    32'(bz));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_cue(tag, COL_WHITE, BR_SEMI, COL_BLACK, BR_FULL, 1'b0);
        chk({tag, ".result_ms"},    32'(result_ms),    32'd0);
        chk({tag, ".result_valid"}, 32'(result_valid), 32'd0);
    endtask

    // Pulse start and follow the cue until green; red_cnt = samples with the red cue.
    task automatic run_to_go();
        bit ok;
        ok = 1'b0;
        pulse(1'b1, 1'b0);
        red_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (color1 == COL_GREEN) begin
                ok = 1'b1;
                break;
            end
            if (color1 == COL_RED) red_cnt++;
            cyc(1);
        end
        chk("go_reached", 32'(ok), 32'd1);
    endtask

    // Called one sample after the green cue appears; press after n more clocks, expect result r.
    task automatic press_result(input string tag, input int r, input int n);
        int       v0;
        bit       nb;
        logic [2:0] exp_c2;
        v0 = valid_cnt;
        nb = BEST_EN && (r < model_best);
        if (nb) model_best = r;
        exp_c2 = nb ? COL_WHITE : COL_GREEN;
        cyc(n);
        pulse(1'b0, 1'b1);
        cyc(1);
        chk({tag, ".valid_hi"}, 32'(result_valid), 32'd1);
        chk({tag, ".result_ms"}, 32'(result_ms), 32'(r));
        chk_cue({tag, ".show"}, COL_BLACK, BR_FULL, exp_c2, BR_FULL, 1'b1);
        cyc(1);
        chk({tag, ".valid_lo"}, 32'(result_valid), 32'd0);
        chk({tag, ".valid_cnt"}, 32'(valid_cnt), 32'(v0 + 1));
    endtask

    // Entered with the sample k clocks after a hold state was entered.
    task automatic hold_then_idle(input string tag, input int k);
        cyc(81 - k);
        chk({tag, ".still_busy"}, 32'(busy), 32'd1);
        cyc(1);
        chk_cue({tag, ".idle"}, COL_WHITE, BR_SEMI, COL_BLACK, BR_FULL, 1'b0);
    endtask

    initial begin
        int v0;

        tbl[0] = '{1'b0, 1'b1, 2, COL_WHITE, BR_SEMI, COL_BLACK, BR_FULL, 1'b0, 12'd5};
        tbl[1] = '{1'b1, 1'b1, 1, COL_RED,   BR_FULL, COL_BLACK, BR_FULL, 1'b1, 12'd5};
        tbl[2] = '{1'b1, 1'b0, 2, COL_RED,   BR_FULL, COL_BLACK, BR_FULL, 1'b1, 12'd5};
        tbl[3] = '{1'b0, 1'b1, 1, COL_RED,   BR_SEMI, COL_RED,   BR_FULL, 1'b1, 12'd5};
        tbl[4] = '{1'b0, 1'b1, 70, COL_RED,  BR_SEMI, COL_RED,   BR_FULL, 1'b1, 12'd5};
        tbl[5] = '{1'b0, 1'b0, 8, COL_RED,   BR_SEMI, COL_RED,   BR_FULL, 1'b1, 12'd5};
        tbl[6] = '{1'b0, 1'b0, 0, COL_WHITE, BR_SEMI, COL_BLACK, BR_FULL, 1'b0, 12'd5};

        // Reset and quiet idle
        cyc(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        cyc(200);
        chk_reset_vals("idle200");

        // Normal press 50 clocks after green
        run_to_go();
        chk("wait_len", 32'((red_cnt >= 41) && (red_cnt <= 111) && ((red_cnt - 1) % 10 == 0)), 32'd1);
        press_result("react5", 5, 49);
        hold_then_idle("react5", 2);

        // Ignored inputs, start+btn together, false start and its hold time
        v0 = valid_cnt;
        for (int i = 0; i < 7; i++) begin
            pulse(tbl[i].s, tbl[i].b);
            cyc(tbl[i].w);
            chk_cue($sformatf("vec%0d", i), tbl[i].c1, tbl[i].b1, tbl[i].c2, tbl[i].b2, tbl[i].bz);
            chk($sformatf("vec%0d.result_ms", i), 32'(result_ms), 32'(tbl[i].res));
        end
        chk("false.no_valid", 32'(valid_cnt), 32'(v0));

        // No press: green for 200 clocks then timeout cue
        v0 = valid_cnt;
        run_to_go();
        cyc(200);
        chk_cue("go_held", COL_GREEN, BR_FULL, COL_BLACK, BR_FULL, 1'b1);
        cyc(1);
        chk_cue("tout", COL_BLACK, BR_FULL, COL_BLUE, BR_FULL, 1'b1);
        hold_then_idle("tout", 1);
        chk("tout.no_valid", 32'(valid_cnt), 32'(v0));
        chk("tout.result_kept", 32'(result_ms), 32'd5);

        // start ignored in GO, press on the timeout clock, start from SHOW, reset mid-WAIT
        run_to_go();
        pulse(1'b1, 1'b0);
        cyc(1);
        chk_cue("go_start_ign", COL_GREEN, BR_FULL, COL_BLACK, BR_FULL, 1'b1);
        press_result("tout_edge", TIMEOUT_MS, 197);
        pulse(1'b1, 1'b0);
        cyc(1);
        chk_cue("show_restart", COL_RED, BR_FULL, COL_BLACK, BR_FULL, 1'b1);
        cyc(10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("mid_wait_rst");
`ifdef BEST_SCORE_EN
        chk("rst.best_ms", 32'(best_ms), 32'hFFF);
`endif
        rst = 1'b0;
        model_best = 4095;
        cyc(2);
        chk_reset_vals("post_rst");

`ifdef BEST_SCORE_EN
        run_to_go();
        press_result("best7", 7, 69);
        chk("best7.best_ms", 32'(best_ms), 32'd7);
        hold_then_idle("best7", 2);
        run_to_go();
        press_result("best5", 5, 49);
        chk("best5.best_ms", 32'(best_ms), 32'd5);
        hold_then_idle("best5", 2);
        run_to_go();
        press_result("best9", 9, 89);
        chk("best9.best_ms", 32'(best_ms), 32'd5);
        hold_then_idle("best9", 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
